// File: rtl/obstacle_engine.sv
// Obstacle manager for the runner game: NUM_SLOTS scrolling obstacles, spawn gaps, speed ramp, render and collision.
// Optional build macro OBST_GODMODE_EN adds a god_mode input that suppresses collision.
module obstacle_engine #(
  parameter int NUM_SLOTS         = 3,
  parameter int NUM_TYPES         = 4,
  parameter int SPRITE_W          = 27,
  parameter int SPRITE_H          = 47,
  parameter int TOP_Y             = 203,
  parameter int SCREEN_W          = 640,
  parameter int MIN_GAP           = 200,
  parameter int GAP_RAND_BITS     = 7,
  parameter int SPEED_INIT        = 2,
  parameter int SPEED_MAX         = 8,
  parameter int SPEED_STEP_FRAMES = 600
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              halt,
  input  logic                                              restart,
  input  logic [9:0]                                        vaddress,
  input  logic [9:0]                                        haddress,
  input  logic [7:0]                                        random,
  output logic [$clog2(NUM_TYPES)+$clog2(SPRITE_H)-1:0]     rom_addr,
  input  logic [SPRITE_W-1:0]                               rom_data,
`ifdef OBST_GODMODE_EN
  input  logic                                              god_mode,
`endif
  input  logic                                              dino_pixel,
  output logic                                              pixel,
  output logic                                              collide,
  output logic [3:0]                                        speed,
  output logic [NUM_SLOTS-1:0]                              active_mask
);

  localparam int TYPE_W  = $clog2(NUM_TYPES);
  localparam int ROW_W   = $clog2(SPRITE_H);
  localparam int COL_W   = $clog2(SPRITE_W);
  localparam int FRAME_W = $clog2(SPEED_STEP_FRAMES);
  localparam logic signed [11:0] X_GONE = 12'(-SPRITE_W);

  typedef enum logic {FREE, ACTIVE} slot_state_t;

  slot_state_t         state_q [NUM_SLOTS];
  slot_state_t         state_d [NUM_SLOTS];
  logic [11:0]         x_q     [NUM_SLOTS];
  logic [11:0]         x_d     [NUM_SLOTS];
  logic [TYPE_W-1:0]   type_q  [NUM_SLOTS];
  logic [TYPE_W-1:0]   type_d  [NUM_SLOTS];
  logic [9:0]          gap_q, gap_d, next_gap_q, next_gap_d;
  logic [3:0]          speed_q, speed_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                tick, spawned;
  logic [11:0]         x_new;
  logic [10:0]         gap_sum;

  assign tick = (vaddress == 10'd480) && (haddress == 10'd0) && !halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || restart) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= FREE;
        x_q[i]     <= 12'(SCREEN_W);
        type_q[i]  <= '0;
      end
      gap_q      <= '0;
      next_gap_q <= 10'(MIN_GAP);
      speed_q    <= 4'(SPEED_INIT);
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      type_q     <= type_d;
      gap_q      <= gap_d;
      next_gap_q <= next_gap_d;
      speed_q    <= speed_d;
      frame_q    <= frame_d;
    end
  end

  // Spawn looks at pre-tick occupancy, so a slot retired on this tick is only reusable next tick.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    type_d     = type_q;
    gap_d      = gap_q;
    next_gap_d = next_gap_q;
    speed_d    = speed_q;
    frame_d    = frame_q;
    spawned    = 1'b0;
    x_new      = '0;
    gap_sum    = '0;
    if (tick) begin
      gap_sum = {1'b0, gap_q} + {7'd0, speed_q};
      gap_d   = gap_sum[10] ? '1 : gap_sum[9:0];
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (state_q[i] == ACTIVE) begin
          x_new = x_q[i] - {8'd0, speed_q};
          if ($signed(x_new) <= X_GONE) begin
            state_d[i] = FREE;
            x_d[i]     = 12'(SCREEN_W);
          end else begin
            x_d[i] = x_new;
          end
        end else if (!spawned && gap_q >= next_gap_q) begin
          spawned    = 1'b1;
          state_d[i] = ACTIVE;
          x_d[i]     = 12'(SCREEN_W);
          type_d[i]  = random[TYPE_W-1:0];
        end
      end
      if (spawned) begin
        gap_d      = '0;
        next_gap_d = 10'(MIN_GAP) + 10'(random[7 -: GAP_RAND_BITS]);
      end
      if (frame_q == FRAME_W'(SPEED_STEP_FRAMES - 1)) begin
        frame_d = '0;
        if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    active_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      active_mask[i] = (state_q[i] == ACTIVE);
    speed = speed_q;
  end

  logic              hit_c, hit_q, hit_d;
  logic [12:0]       diff;
  logic [COL_W-1:0]  col_c, col_q, col_d;
  logic [TYPE_W-1:0] sel_type;
  logic              v_in;

  assign v_in = (vaddress >= 10'(TOP_Y)) && (vaddress < 10'(TOP_Y + SPRITE_H));

  always_comb begin
    hit_c    = 1'b0;
    col_c    = '0;
    sel_type = '0;
    diff     = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      diff = {3'b000, haddress} - {x_q[i][11], x_q[i]};
      if (!hit_c && state_q[i] == ACTIVE && v_in && haddress < 10'(SCREEN_W) &&
          !diff[12] && diff[11:0] < 12'(SPRITE_W)) begin
        hit_c    = 1'b1;
        col_c    = COL_W'(diff);
        sel_type = type_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || restart) begin
      rom_addr <= '0;
      hit_q    <= 1'b0;
      col_q    <= '0;
      hit_d    <= 1'b0;
      col_d    <= '0;
      pixel    <= 1'b0;
      collide  <= 1'b0;
    end else begin
      hit_q <= hit_c;
      if (hit_c) begin
        rom_addr <= {sel_type, ROW_W'(vaddress - 10'(TOP_Y))};
        col_q    <= col_c;
      end
      hit_d <= hit_q;
      col_d <= col_q;
      pixel <= hit_d & rom_data[col_d];
`ifdef OBST_GODMODE_EN
      collide <= god_mode ? 1'b0 : (collide | (pixel & dino_pixel));
`else
      collide <= collide | (pixel & dino_pixel);
`endif
    end
  end

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: spawn timing, deferral, speed ramp, render latency, collision, reset/restart.
module tb_obstacle_engine;

  logic        clk = 1'b0;
  logic        reset_n, halt, restart, dino_pixel;
  logic [9:0]  vaddress, haddress;
  logic [7:0]  random;
  logic [7:0]  rom_addr;
  logic [26:0] rom_data;
  logic        pixel, collide;
  logic [3:0]  speed;
  logic [2:0]  active_mask;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  a;
  logic        p2, p3;

  localparam logic [26:0] ROM_SPECIAL = 27'h20;

  always #5 clk = ~clk;

  // Synchronous sprite ROM: row {2,7} holds only bit 5, every other row is solid.
  always @(posedge clk) rom_data <= (rom_addr == 8'h87) ? ROM_SPECIAL : '1;

  obstacle_engine dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .halt        (halt),
    .restart     (restart),
    .vaddress    (vaddress),
    .haddress    (haddress),
    .random      (random),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .dino_pixel  (dino_pixel),
    .pixel       (pixel),
    .collide     (collide),
    .speed       (speed),
    .active_mask (active_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    @(negedge clk);
    vaddress = 10'd480;
    haddress = 10'd0;
    repeat (n) @(negedge clk);
    vaddress = 10'd0;
  endtask

  task automatic scan(input logic [9:0] v, input logic [9:0] h,
                      output logic [7:0] addr1, output logic pix2, output logic pix3);
    @(negedge clk);
    vaddress = v;
    haddress = h;
    @(negedge clk);
    vaddress = 10'd0;
    haddress = 10'd0;
    addr1 = rom_addr;
    @(negedge clk);
    pix2 = pixel;
    @(negedge clk);
    pix3 = pixel;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; halt = 1'b0; restart = 1'b0; dino_pixel = 1'b0;
    vaddress = '0; haddress = '0; random = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pixel", pixel, 0);
    check("rst_collide", collide, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_mask", active_mask, 0);
    check("rst_speed", speed, 2);
    reset_n = 1'b1;

    // First spawn needs gap_cnt >= 200, reached before tick 101 at speed 2.
    ticks(100);
    check("no_spawn_early", active_mask, 0);
    ticks(1);
    check("spawn_slot0", active_mask, 3'b001);
    ticks(1);
    scan(10'd203, 10'd638, a, p2, p3);
    check("x638_addr", a, 8'h00);
    check("x638_pix", p3, 1);
    scan(10'd203, 10'd637, a, p2, p3);
    check("left_of_sprite", p3, 0);
    scan(10'd203, 10'd640, a, p2, p3);
    check("off_screen_right", p3, 0);

    ticks(100);
    check("spawn_slot1", active_mask, 3'b011);
    ticks(101);
    check("spawn_slot2", active_mask, 3'b111);
    ticks(131);
    check("deferred_full", active_mask, 3'b111);
    scan(10'd203, 10'd0, a, p2, p3);
    check("left_edge_partial", p3, 1);
    ticks(1);
    check("slot0_freed", active_mask, 3'b110);
    ticks(1);
    check("deferred_spawn", active_mask, 3'b111);

    ticks(163);
    check("speed_599", speed, 2);
    halt = 1'b1;
    ticks(50);
    halt = 1'b0;
    check("halt_no_ramp", speed, 2);
    ticks(1);
    check("speed_600", speed, 3);
    ticks(2999);
    check("speed_3599", speed, 7);
    ticks(1);
    check("speed_3600", speed, 8);
    ticks(600);
    check("speed_sat", speed, 8);

    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    check("restart_mask", active_mask, 0);
    check("restart_speed", speed, 2);

    // Slot0 gets type 2 and reaches x=100 after 371 ticks.
    random = 8'h02;
    ticks(100);
    check("restart_gap", active_mask, 0);
    ticks(1);
    check("respawn", active_mask, 3'b001);
    ticks(270);
    scan(10'd210, 10'd105, a, p2, p3);
    check("rom_addr_t2_r7", a, 8'h87);
    check("pix_cycle2", p2, 0);
    check("pix_cycle3", p3, 1);
    check("collide_before", collide, 0);
    dino_pixel = 1'b1;
    @(negedge clk) dino_pixel = 1'b0;
    check("collide_set", collide, 1);
    scan(10'd210, 10'd104, a, p2, p3);
    check("col4_blank", p3, 0);
    scan(10'd249, 10'd100, a, p2, p3);
    check("bottom_row_addr", a, 8'hAE);
    check("bottom_row_pix", p3, 1);
    scan(10'd250, 10'd100, a, p2, p3);
    check("below_sprite", p3, 0);
    check("rom_addr_hold", a, 8'hAE);
    scan(10'd202, 10'd100, a, p2, p3);
    check("above_sprite", p3, 0);
    halt = 1'b1;
    repeat (20) @(negedge clk);
    check("collide_sticky", collide, 1);
    scan(10'd210, 10'd105, a, p2, p3);
    check("render_halted", p3, 1);
    dino_pixel = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    dino_pixel = 1'b0;
    check("restart_collide", collide, 0);
    check("restart_mask2", active_mask, 0);
    check("restart_speed2", speed, 2);
    halt = 1'b0;

    // Async reset mid-frame with a live overlap on screen; slot0 at x=620.
    ticks(111);
    check("pre_rst_mask", active_mask, 3'b001);
    @(negedge clk);
    vaddress = 10'd206;
    haddress = 10'd625;
    repeat (4) @(negedge clk);
    dino_pixel = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_pixel", pixel, 1);
    check("pre_rst_collide", collide, 1);
    check("pre_rst_addr", rom_addr, 8'h83);
    reset_n = 1'b0;
    #1;
    check("async_pixel", pixel, 0);
    check("async_collide", collide, 0);
    check("async_addr", rom_addr, 0);
    check("async_mask", active_mask, 0);
    check("async_speed", speed, 2);
    @(negedge clk);
    vaddress = '0;
    haddress = '0;
    dino_pixel = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    ticks(100);
    check("post_rst_gap", active_mask, 0);
    ticks(1);
    check("post_rst_spawn", active_mask, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
